// File: rtl/control_sequencer.sv
// Microcode control sequencer for the 8-bit computer.
// Decodes opcode and T-state into the bus control word, keeps the ZERO/CARRY
// flags for conditional jumps and holds the machine once HLT executes.
module control_sequencer #(
  parameter bit EARLY_END = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       zero_in,
  input  logic       carry_in,
  output logic [2:0] step,
  output logic       flag_z,
  output logic       flag_c,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       io,
  output logic       ii,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic       fi
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_t;

  step_e   step_q, step_d;
  logic    flag_z_q, flag_z_d;
  logic    flag_c_q, flag_c_d;
  logic    halted_q, halted_d;
  opcode_e op;
  step_e   last_step;
  ctrl_t   ctrl;
  ctrl_t   ctrl_out;
  logic    unused_operand;

  assign op             = opcode_e'(instr[7:4]);
  assign unused_operand = ^instr[3:0];

  // Last active T-state of the current opcode, used for early step return.
  always_comb begin
    last_step = T1;
    case (op)
      OP_LDA, OP_STA:                         last_step = T3;
      OP_ADD, OP_SUB:                         last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
      OP_HLT:                                 last_step = T2;
      default:                                last_step = T1;
    endcase
  end

  // Control word decode from T-state, opcode, flags and halt state.
  always_comb begin
    ctrl = '0;
    if (halted_q) begin
      ctrl.hlt = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          ctrl.co = 1'b1;
          ctrl.mi = 1'b1;
        end
        T1: begin
          ctrl.ro = 1'b1;
          ctrl.ii = 1'b1;
          ctrl.ce = 1'b1;
        end
        T2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.io = 1'b1;
              ctrl.mi = 1'b1;
            end
            OP_LDI: begin
              ctrl.io = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_JMP: begin
              ctrl.io = 1'b1;
              ctrl.j  = 1'b1;
            end
            OP_JC: begin
              ctrl.io = flag_c_q;
              ctrl.j  = flag_c_q;
            end
            OP_JZ: begin
              ctrl.io = flag_z_q;
              ctrl.j  = flag_z_q;
            end
            OP_OUT: begin
              ctrl.ao = 1'b1;
              ctrl.oi = 1'b1;
            end
            OP_HLT: ctrl.hlt = 1'b1;
            default: ctrl = '0;
          endcase
        end
        T3: begin
          case (op)
            OP_LDA: begin
              ctrl.ro = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ro = 1'b1;
              ctrl.bi = 1'b1;
            end
            OP_STA: begin
              ctrl.ao = 1'b1;
              ctrl.ri = 1'b1;
            end
            default: ctrl = '0;
          endcase
        end
        T4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            ctrl.eo = 1'b1;
            ctrl.ai = 1'b1;
            ctrl.fi = 1'b1;
            ctrl.su = (op == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  // Controls are held low for the whole time reset is asserted.
  assign ctrl_out = rst_n ? ctrl : '0;

  // Next step counter, flags and halt state.
  always_comb begin
    step_d   = step_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (ctrl.fi) begin
        flag_z_d = zero_in;
        flag_c_d = carry_in;
      end
      if (ctrl.hlt) begin
        // HLT freezes the counter on T2 from the very edge that halts.
        halted_d = 1'b1;
        step_d   = step_q;
      end else if (EARLY_END && step_q == last_step) begin
        step_d = T0;
      end else begin
        case (step_q)
          T0:      step_d = T1;
          T1:      step_d = T2;
          T2:      step_d = T3;
          T3:      step_d = T4;
          default: step_d = T0;
        endcase
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= T0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      halted_q <= halted_d;
    end
  end

  assign step   = step_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign hlt    = ctrl_out.hlt;
  assign mi     = ctrl_out.mi;
  assign ri     = ctrl_out.ri;
  assign ro     = ctrl_out.ro;
  assign io     = ctrl_out.io;
  assign ii     = ctrl_out.ii;
  assign ai     = ctrl_out.ai;
  assign ao     = ctrl_out.ao;
  assign eo     = ctrl_out.eo;
  assign su     = ctrl_out.su;
  assign bi     = ctrl_out.bi;
  assign oi     = ctrl_out.oi;
  assign ce     = ctrl_out.ce;
  assign co     = ctrl_out.co;
  assign j      = ctrl_out.j;
  assign fi     = ctrl_out.fi;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: one instance per EARLY_END setting.
module tb_control_sequencer;

  localparam logic [15:0] K_HLT = 16'h8000, K_MI = 16'h4000, K_RI = 16'h2000,
                          K_RO  = 16'h1000, K_IO = 16'h0800, K_II = 16'h0400,
                          K_AI  = 16'h0200, K_AO = 16'h0100, K_EO = 16'h0080,
                          K_SU  = 16'h0040, K_BI = 16'h0020, K_OI = 16'h0010,
                          K_CE  = 16'h0008, K_CO = 16'h0004, K_J  = 16'h0002,
                          K_FI  = 16'h0001;

  typedef struct packed {
    logic        sel;
    logic [2:0]  step;
    logic [15:0] ctrl;
    logic [1:0]  flags;
  } exp_t;

  bit         clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       zero_in, carry_in;

  logic [2:0] step0, step1;
  logic       fz0, fc0, fz1, fc1;
  logic       hlt0, mi0, ri0, ro0, io0, ii0, ai0, ao0, eo0, su0, bi0, oi0, ce0, co0, j0, fi0;
  logic       hlt1, mi1, ri1, ro1, io1, ii1, ai1, ao1, eo1, su1, bi1, oi1, ce1, co1, j1, fi1;
  logic [15:0] ctrl0, ctrl1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  control_sequencer #(.EARLY_END(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero_in(zero_in), .carry_in(carry_in),
    .step(step0), .flag_z(fz0), .flag_c(fc0), .hlt(hlt0), .mi(mi0), .ri(ri0),
    .ro(ro0), .io(io0), .ii(ii0), .ai(ai0), .ao(ao0), .eo(eo0), .su(su0),
    .bi(bi0), .oi(oi0), .ce(ce0), .co(co0), .j(j0), .fi(fi0)
  );

  control_sequencer #(.EARLY_END(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero_in(zero_in), .carry_in(carry_in),
    .step(step1), .flag_z(fz1), .flag_c(fc1), .hlt(hlt1), .mi(mi1), .ri(ri1),
    .ro(ro1), .io(io1), .ii(ii1), .ai(ai1), .ao(ao1), .eo(eo1), .su(su1),
    .bi(bi1), .oi(oi1), .ce(ce1), .co(co1), .j(j1), .fi(fi1)
  );

  assign ctrl0 = {hlt0, mi0, ri0, ro0, io0, ii0, ai0, ao0, eo0, su0, bi0, oi0, ce0, co0, j0, fi0};
  assign ctrl1 = {hlt1, mi1, ri1, ro1, io1, ii1, ai1, ao1, eo1, su1, bi1, oi1, ce1, co1, j1, fi1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s (#%0d, t=%0t): got %0h expected %0h", tag, total, $time, obs, exp);
    end
  endtask

  // Pop one expected record per falling edge and compare against the selected DUT.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel == 1'b0) begin
        check("ee0_step",  {29'd0, step0}, {29'd0, e.step});
        check("ee0_ctrl",  {16'd0, ctrl0}, {16'd0, e.ctrl});
        check("ee0_flags", {30'd0, fz0, fc0}, {30'd0, e.flags});
      end else begin
        check("ee1_step",  {29'd0, step1}, {29'd0, e.step});
        check("ee1_ctrl",  {16'd0, ctrl1}, {16'd0, e.ctrl});
        check("ee1_flags", {30'd0, fz1, fc1}, {30'd0, e.flags});
      end
    end
  end

  task automatic push_exp(input logic sel, input logic [2:0] st, input logic [15:0] c,
                          input logic fz, input logic fc);
    exp_t x;
    x.sel   = sel;
    x.step  = st;
    x.ctrl  = c;
    x.flags = {fz, fc};
    sb.push_back(x);
  endtask

  // One clock: expectation for the current cycle, then advance past the next edge.
  task automatic cyc(input logic sel, input logic [2:0] st, input logic [15:0] c,
                     input logic fz, input logic fc);
    push_exp(sel, st, c, fz, fc);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic sel, input logic [7:0] ins, input int unsigned n,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                           input logic fz, input logic fc);
    instr = ins;
    cyc(sel, 3'd0, K_CO | K_MI, fz, fc);
    cyc(sel, 3'd1, K_RO | K_II | K_CE, fz, fc);
    if (n > 2) cyc(sel, 3'd2, e2, fz, fc);
    if (n > 3) cyc(sel, 3'd3, e3, fz, fc);
    if (n > 4) cyc(sel, 3'd4, e4, fz, fc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    instr    = 8'h00;
    zero_in  = 1'b0;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Fixed five-step sequencing
    run_instr(1'b0, 8'h00, 5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    zero_in = 1'b1; carry_in = 1'b1;
    run_instr(1'b0, 8'h3E, 5, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_SU | K_FI, 1'b0, 1'b0);
    zero_in = 1'b0; carry_in = 1'b0;
    run_instr(1'b0, 8'h2E, 5, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI, 1'b1, 1'b1);
    run_instr(1'b0, 8'h1A, 5, K_IO | K_MI, K_RO | K_AI, 16'h0, 1'b0, 1'b0);
    run_instr(1'b0, 8'h4B, 5, K_IO | K_MI, K_AO | K_RI, 16'h0, 1'b0, 1'b0);
    run_instr(1'b0, 8'h57, 5, K_IO | K_AI, 16'h0, 16'h0, 1'b0, 1'b0);
    run_instr(1'b0, 8'h63, 5, K_IO | K_J, 16'h0, 16'h0, 1'b0, 1'b0);
    run_instr(1'b0, 8'hE0, 5, K_AO | K_OI, 16'h0, 16'h0, 1'b0, 1'b0);
    run_instr(1'b0, 8'h9C, 5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Conditional jumps against flags set by the preceding ALU op
    carry_in = 1'b1;
    run_instr(1'b0, 8'h3E, 5, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_SU | K_FI, 1'b0, 1'b0);
    carry_in = 1'b0;
    run_instr(1'b0, 8'h75, 5, K_IO | K_J, 16'h0, 16'h0, 1'b0, 1'b1);
    run_instr(1'b0, 8'h85, 5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    zero_in = 1'b1;
    run_instr(1'b0, 8'h2E, 5, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI, 1'b0, 1'b1);
    zero_in = 1'b0;
    run_instr(1'b0, 8'h75, 5, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    run_instr(1'b0, 8'h85, 5, K_IO | K_J, 16'h0, 16'h0, 1'b1, 1'b0);

    // Halt: frozen at T2 regardless of new instruction or ALU inputs
    run_instr(1'b0, 8'hF0, 3, K_HLT, 16'h0, 16'h0, 1'b1, 1'b0);
    instr = 8'h3E; carry_in = 1'b1;
    repeat (10) cyc(1'b0, 3'd2, K_HLT, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    carry_in = 1'b0;

    // Asynchronous reset in the middle of an ADD at T3
    zero_in = 1'b1; carry_in = 1'b1;
    run_instr(1'b0, 8'h3E, 5, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_SU | K_FI, 1'b0, 1'b0);
    zero_in = 1'b0; carry_in = 1'b0;
    run_instr(1'b0, 8'h2E, 3, K_IO | K_MI, 16'h0, 16'h0, 1'b1, 1'b1);
    push_exp(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Early return to T0
    run_instr(1'b1, 8'h53, 3, K_IO | K_AI, 16'h0, 16'h0, 1'b0, 1'b0);
    run_instr(1'b1, 8'h00, 2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    run_instr(1'b1, 8'h1F, 4, K_IO | K_MI, K_RO | K_AI, 16'h0, 1'b0, 1'b0);
    carry_in = 1'b1;
    run_instr(1'b1, 8'h3E, 5, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_SU | K_FI, 1'b0, 1'b0);
    carry_in = 1'b0;
    run_instr(1'b1, 8'h75, 3, K_IO | K_J, 16'h0, 16'h0, 1'b0, 1'b1);
    run_instr(1'b1, 8'h2A, 5, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI, 1'b0, 1'b1);
    run_instr(1'b1, 8'h75, 3, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, K_CO | K_MI, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
